// File: rtl/sc_alu_arbiter_pkg.sv
// ============================================================================
// sc_alu_arbiter_pkg : shared word size, ALU opcode encodings for sc_alu users
// Revision: 1.0
// ============================================================================
`default_nettype none

package sc_alu_arbiter_pkg;
  localparam int SC_WORD_SIZE = 32;
  localparam int SC_ALU_OP_W  = 3;

  typedef enum logic [SC_ALU_OP_W-1:0] {
    SC_ALU_ADD = 3'd0,
    SC_ALU_SUB = 3'd1,
    SC_ALU_AND = 3'd2,
    SC_ALU_OR  = 3'd3,
    SC_ALU_XOR = 3'd4,
    SC_ALU_SLL = 3'd5,
    SC_ALU_SRL = 3'd6,
    SC_ALU_SRA = 3'd7
  } alu_op_e;

  // Idle ALU cycles issue an ADD of zeros; the result is never captured.
  localparam alu_op_e SC_ALU_NOP = SC_ALU_ADD;
endpackage

`default_nettype wire

// File: rtl/sc_alu_arbiter_if.sv
// ============================================================================
// sc_alu_arbiter_if : one requester's request and response valid/ready channels
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sc_alu_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                         req_valid;
  logic                         req_ready;
  sc_alu_arbiter_pkg::alu_op_e  req_op;
  logic [WORD_SIZE-1:0]         req_a;
  logic [WORD_SIZE-1:0]         req_b;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [WORD_SIZE-1:0]         resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

`default_nettype wire

// File: rtl/sc_alu.sv
// ============================================================================
// sc_alu : registered single-cycle-latency ALU (result valid the cycle after)
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_alu
  import sc_alu_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = SC_WORD_SIZE
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire alu_op_e              alu_op_in,
  input  wire logic [WORD_SIZE-1:0] alu_a_in,
  input  wire logic [WORD_SIZE-1:0] alu_b_in,
  output logic      [WORD_SIZE-1:0] alu_out
);
  localparam int C_SHAMT_W = $clog2(WORD_SIZE);

  logic [C_SHAMT_W-1:0] w_shamt;
  logic [WORD_SIZE-1:0] w_result;

  assign w_shamt = alu_b_in[C_SHAMT_W-1:0];

  always_comb begin
    w_result = '0;
    case (alu_op_in)
      SC_ALU_ADD: w_result = alu_a_in + alu_b_in;
      SC_ALU_SUB: w_result = alu_a_in - alu_b_in;
      SC_ALU_AND: w_result = alu_a_in & alu_b_in;
      SC_ALU_OR:  w_result = alu_a_in | alu_b_in;
      SC_ALU_XOR: w_result = alu_a_in ^ alu_b_in;
      SC_ALU_SLL: w_result = alu_a_in << w_shamt;
      SC_ALU_SRL: w_result = alu_a_in >> w_shamt;
      SC_ALU_SRA: w_result = $signed(alu_a_in) >>> w_shamt;
      default:    w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_out <= '0;
    else        alu_out <= w_result;
  end
endmodule

`default_nettype wire

// File: rtl/sc_rr_arb2.sv
// ============================================================================
// sc_rr_arb2 : 2-way round-robin / fixed-priority one-hot grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  wire logic [1:0] i_eligible,
  input  wire logic       i_last_grant,
  output logic      [1:0] o_grant
);
  always_comb begin
    o_grant = i_eligible;
    if (&i_eligible) begin
      // Under contention the requester that did not win last time goes next.
      if (RR_EN && (i_last_grant == 1'b0)) o_grant = 2'b10;
      else                                 o_grant = 2'b01;
    end
  end
endmodule

`default_nettype wire

// File: rtl/sc_alu_arbiter.sv
// ============================================================================
// sc_alu_arbiter : shares one registered sc_alu between two requesters
// Revision: 1.0
// ============================================================================
`default_nettype none

module sc_alu_arbiter
  import sc_alu_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = SC_WORD_SIZE,
  parameter bit RR_EN     = 1'b1
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  sc_alu_arbiter_if.slave           req0,
  sc_alu_arbiter_if.slave           req1,
  output alu_op_e                   alu_op_out,
  output logic      [WORD_SIZE-1:0] alu_a_out,
  output logic      [WORD_SIZE-1:0] alu_b_out,
  input  wire logic [WORD_SIZE-1:0] alu_in,
  output logic                      busy
);
  logic                 r_inflight_v;
  logic                 r_inflight_id;
  logic                 r_last_grant;
  logic [1:0]           r_resp_valid;
  logic [WORD_SIZE-1:0] r_resp_data0;
  logic [WORD_SIZE-1:0] r_resp_data1;

  logic [1:0]           w_eligible;
  logic [1:0]           w_grant;

  // A requester with its op still in the ALU, or with a full response slot
  // that is not draining this cycle, cannot issue; this also keeps drain and
  // capture of a slot from ever landing on the same edge.
  assign w_eligible[0] = rst_n & req0.req_valid
                       & ~(r_inflight_v & (r_inflight_id == 1'b0))
                       & (~r_resp_valid[0] | req0.resp_ready);
  assign w_eligible[1] = rst_n & req1.req_valid
                       & ~(r_inflight_v & (r_inflight_id == 1'b1))
                       & (~r_resp_valid[1] | req1.resp_ready);

  sc_rr_arb2 #(
    .RR_EN        (RR_EN)
  ) u_arb (
    .i_eligible   (w_eligible),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  always_comb begin
    alu_op_out = SC_ALU_NOP;
    alu_a_out  = '0;
    alu_b_out  = '0;
    if (w_grant[0]) begin
      alu_op_out = req0.req_op;
      alu_a_out  = req0.req_a;
      alu_b_out  = req0.req_b;
    end else if (w_grant[1]) begin
      alu_op_out = req1.req_op;
      alu_a_out  = req1.req_a;
      alu_b_out  = req1.req_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight_v  <= 1'b0;
      r_inflight_id <= 1'b0;
      r_last_grant  <= 1'b1;
      r_resp_valid  <= 2'b00;
      r_resp_data0  <= '0;
      r_resp_data1  <= '0;
    end else begin
      r_inflight_v <= |w_grant;
      if (|w_grant) begin
        r_inflight_id <= w_grant[1];
        r_last_grant  <= w_grant[1];
      end

      if (r_resp_valid[0] && req0.resp_ready) r_resp_valid[0] <= 1'b0;
      if (r_resp_valid[1] && req1.resp_ready) r_resp_valid[1] <= 1'b0;

      if (r_inflight_v) begin
        if (r_inflight_id == 1'b0) begin
          r_resp_valid[0] <= 1'b1;
          r_resp_data0    <= alu_in;
        end else begin
          r_resp_valid[1] <= 1'b1;
          r_resp_data1    <= alu_in;
        end
      end
    end
  end

  assign req0.req_ready  = w_grant[0];
  assign req1.req_ready  = w_grant[1];
  assign req0.resp_valid = r_resp_valid[0];
  assign req1.resp_valid = r_resp_valid[1];
  assign req0.resp_data  = r_resp_data0;
  assign req1.resp_data  = r_resp_data1;
  assign busy            = r_inflight_v | r_resp_valid[0] | r_resp_valid[1];
endmodule

`default_nettype wire

// File: tb/tb_sc_alu_arbiter.sv
// ============================================================================
// tb_sc_alu_arbiter : directed checks of sc_alu_arbiter driving a real sc_alu
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sc_alu_arbiter;
  import sc_alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sc_alu_arbiter_if #(.WORD_SIZE(32)) r0 ();
  sc_alu_arbiter_if #(.WORD_SIZE(32)) r1 ();
  sc_alu_arbiter_if #(.WORD_SIZE(32)) f0 ();
  sc_alu_arbiter_if #(.WORD_SIZE(32)) f1 ();

  alu_op_e     rr_op, fp_op;
  logic [31:0] rr_a, rr_b, rr_alu, fp_a, fp_b, fp_alu;
  logic        rr_busy, fp_busy;

  sc_alu_arbiter #(.WORD_SIZE(32), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req0(r0), .req1(r1),
    .alu_op_out(rr_op), .alu_a_out(rr_a), .alu_b_out(rr_b),
    .alu_in(rr_alu), .busy(rr_busy)
  );
  sc_alu #(.WORD_SIZE(32)) u_rr_alu (
    .clk(clk), .rst_n(rst_n), .alu_op_in(rr_op), .alu_a_in(rr_a),
    .alu_b_in(rr_b), .alu_out(rr_alu)
  );

  sc_alu_arbiter #(.WORD_SIZE(32), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req0(f0), .req1(f1),
    .alu_op_out(fp_op), .alu_a_out(fp_a), .alu_b_out(fp_b),
    .alu_in(fp_alu), .busy(fp_busy)
  );
  sc_alu #(.WORD_SIZE(32)) u_fp_alu (
    .clk(clk), .rst_n(rst_n), .alu_op_in(fp_op), .alu_a_in(fp_a),
    .alu_b_in(fp_b), .alu_out(fp_alu)
  );

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    r0.req_valid = v; r0.req_op = op; r0.req_a = a; r0.req_b = b;
  endtask

  task automatic drv1(input logic v, input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    r1.req_valid = v; r1.req_op = op; r1.req_a = a; r1.req_b = b;
  endtask

  task automatic idle_all();
    drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    drv1(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    r0.resp_ready = 1'b0; r1.resp_ready = 1'b0;
    f0.req_valid = 1'b0; f0.req_op = SC_ALU_ADD; f0.req_a = '0; f0.req_b = '0; f0.resp_ready = 1'b0;
    f1.req_valid = 1'b0; f1.req_op = SC_ALU_ADD; f1.req_a = '0; f1.req_b = '0; f1.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_all();
    rst_n = 1'b0;

    // Reset: outputs quiet even with a request presented.
    drv0(1'b1, SC_ALU_SUB, 32'h11, 32'h22);
    step(); step();
    check_eq("rst_req0_ready", 32'(r0.req_ready), 32'd0);
    check_eq("rst_alu_op", 32'(rr_op), 32'd0);
    check_eq("rst_alu_a", rr_a, 32'd0);
    check_eq("rst_alu_b", rr_b, 32'd0);
    check_eq("rst_busy", 32'(rr_busy), 32'd0);
    check_eq("rst_resp0_valid", 32'(r0.resp_valid), 32'd0);
    check_eq("rst_resp1_data", r1.resp_data, 32'd0);
    drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    rst_n = 1'b1;
    step();

    // Test 1: single ADD 5+7.
    drv0(1'b1, SC_ALU_ADD, 32'd5, 32'd7); #1;
    check_eq("t1_ready_c0", 32'(r0.req_ready), 32'd1);
    check_eq("t1_alu_a_c0", rr_a, 32'd5);
    check_eq("t1_busy_c0", 32'(rr_busy), 32'd0);
    step(); drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0); #1;
    check_eq("t1_busy_c1", 32'(rr_busy), 32'd1);
    check_eq("t1_resp_valid_c1", 32'(r0.resp_valid), 32'd0);
    check_eq("t1_alu_out_c1", rr_alu, 32'd12);
    step();
    check_eq("t1_resp_valid_c2", 32'(r0.resp_valid), 32'd1);
    check_eq("t1_resp_data_c2", r0.resp_data, 32'd12);
    check_eq("t1_busy_c2", 32'(rr_busy), 32'd1);
    r0.resp_ready = 1'b1;
    step(); r0.resp_ready = 1'b0; #1;
    check_eq("t1_resp_valid_c3", 32'(r0.resp_valid), 32'd0);
    check_eq("t1_busy_c3", 32'(rr_busy), 32'd0);

    // Test 2: round-robin contention from a fresh reset.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();
    drv0(1'b1, SC_ALU_SUB, 32'd10, 32'd3);
    drv1(1'b1, SC_ALU_XOR, 32'h0000_00F0, 32'h0000_000F);
    r0.resp_ready = 1'b1; r1.resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq($sformatf("t2_ready0_c%0d", c), 32'(r0.req_ready), 32'((c % 2) == 0));
      check_eq($sformatf("t2_ready1_c%0d", c), 32'(r1.req_ready), 32'((c % 2) == 1));
      check_eq($sformatf("t2_resp0v_c%0d", c), 32'(r0.resp_valid), 32'(c >= 2 && (c % 2) == 0));
      check_eq($sformatf("t2_resp1v_c%0d", c), 32'(r1.resp_valid), 32'(c >= 3 && (c % 2) == 1));
      if (c == 2) check_eq("t2_resp0_data", r0.resp_data, 32'd7);
      if (c == 3) check_eq("t2_resp1_data", r1.resp_data, 32'h0000_00FF);
      step();
    end
    drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    drv1(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    step(); step(); step();
    check_eq("t2_busy_drained", 32'(rr_busy), 32'd0);

    // Test 4: backpressure on resp0 while req1 proceeds.
    r0.resp_ready = 1'b0; r1.resp_ready = 1'b1;
    drv0(1'b1, SC_ALU_SLL, 32'd1, 32'd4); #1;
    check_eq("t4_ready0_c0", 32'(r0.req_ready), 32'd1);
    step(); drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    step();
    check_eq("t4_resp0_valid_c2", 32'(r0.resp_valid), 32'd1);
    check_eq("t4_resp0_data_c2", r0.resp_data, 32'd16);
    drv0(1'b1, SC_ALU_ADD, 32'd1, 32'd1);
    drv1(1'b1, SC_ALU_AND, 32'h0000_00FF, 32'h0000_000F); #1;
    check_eq("t4_ready0_c2", 32'(r0.req_ready), 32'd0);
    check_eq("t4_ready1_c2", 32'(r1.req_ready), 32'd1);
    step(); drv1(1'b0, SC_ALU_ADD, 32'd0, 32'd0); #1;
    check_eq("t4_ready0_c3", 32'(r0.req_ready), 32'd0);
    step();
    check_eq("t4_ready0_c4", 32'(r0.req_ready), 32'd0);
    check_eq("t4_resp1_valid_c4", 32'(r1.resp_valid), 32'd1);
    check_eq("t4_resp1_data_c4", r1.resp_data, 32'h0000_000F);
    step();
    r0.resp_ready = 1'b1; #1;
    check_eq("t4_ready0_release", 32'(r0.req_ready), 32'd1);
    check_eq("t4_resp0_hold", r0.resp_data, 32'd16);
    step(); drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0); #1;
    check_eq("t4_resp0_drained", 32'(r0.resp_valid), 32'd0);
    step();
    check_eq("t4_resp0_valid_new", 32'(r0.resp_valid), 32'd1);
    check_eq("t4_resp0_data_new", r0.resp_data, 32'd2);
    // Last winner was req0, so round-robin now favours req1.
    drv0(1'b1, SC_ALU_ADD, 32'd3, 32'd3);
    drv1(1'b1, SC_ALU_ADD, 32'd4, 32'd4); #1;
    check_eq("t4_rr_ready1", 32'(r1.req_ready), 32'd1);
    check_eq("t4_rr_ready0", 32'(r0.req_ready), 32'd0);
    step(); drv1(1'b0, SC_ALU_ADD, 32'd0, 32'd0); #1;
    check_eq("t4_rr_next_ready0", 32'(r0.req_ready), 32'd1);
    step(); drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    step(); step(); step();
    check_eq("t4_busy_drained", 32'(rr_busy), 32'd0);

    // Test 5: async reset one cycle after accepting req1 OR.
    r1.resp_ready = 1'b0;
    drv1(1'b1, SC_ALU_OR, 32'h0000_00A0, 32'h0000_0005); #1;
    check_eq("t5_ready1_c0", 32'(r1.req_ready), 32'd1);
    step(); drv1(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    rst_n = 1'b0; #1;
    check_eq("t5_busy_in_rst", 32'(rr_busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("t5_resp1v_after_c%0d", c), 32'(r1.resp_valid), 32'd0);
      step();
    end
    check_eq("t5_busy_after", 32'(rr_busy), 32'd0);
    drv0(1'b1, SC_ALU_ADD, 32'd0, 32'd0);
    drv1(1'b1, SC_ALU_ADD, 32'd0, 32'd0); #1;
    check_eq("t5_first_win_ready0", 32'(r0.req_ready), 32'd1);
    check_eq("t5_first_win_ready1", 32'(r1.req_ready), 32'd0);
    step();
    drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    drv1(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    r0.resp_ready = 1'b1; r1.resp_ready = 1'b1;
    step(); step(); step(); step();

    // Test 6: logical and arithmetic right shifts.
    r0.resp_ready = 1'b0; r1.resp_ready = 1'b0;
    drv1(1'b1, SC_ALU_SRL, 32'h8000_0000, 32'd4); #1;
    check_eq("t6_ready1", 32'(r1.req_ready), 32'd1);
    step(); drv1(1'b0, SC_ALU_ADD, 32'd0, 32'd0); #1;
    check_eq("t6_alu_srl", rr_alu, 32'h0800_0000);
    step();
    check_eq("t6_resp1_valid", 32'(r1.resp_valid), 32'd1);
    check_eq("t6_resp1_srl", r1.resp_data, 32'h0800_0000);
    r1.resp_ready = 1'b1;
    drv0(1'b1, SC_ALU_SRA, 32'h8000_0000, 32'd4); #1;
    check_eq("t6_ready0", 32'(r0.req_ready), 32'd1);
    step(); drv0(1'b0, SC_ALU_ADD, 32'd0, 32'd0);
    step();
    check_eq("t6_resp0_valid", 32'(r0.resp_valid), 32'd1);
    check_eq("t6_resp0_sra", r0.resp_data, 32'hF800_0000);
    r0.resp_ready = 1'b1;
    step(); step();

    // Test 3: fixed priority; req0 wins even right after its own grant.
    f0.resp_ready = 1'b1; f1.resp_ready = 1'b1;
    f0.req_valid = 1'b1; f0.req_op = SC_ALU_ADD; f0.req_a = 32'd2; f0.req_b = 32'd3; #1;
    check_eq("t3_ready0_c0", 32'(f0.req_ready), 32'd1);
    step(); f0.req_valid = 1'b0;
    step();
    f0.req_valid = 1'b1; f0.req_op = SC_ALU_SUB; f0.req_a = 32'd9; f0.req_b = 32'd2;
    f1.req_valid = 1'b1; f1.req_op = SC_ALU_ADD; f1.req_a = 32'd1; f1.req_b = 32'd1; #1;
    check_eq("t3_ready0_c2", 32'(f0.req_ready), 32'd1);
    check_eq("t3_ready1_c2", 32'(f1.req_ready), 32'd0);
    check_eq("t3_resp0_data_c2", f0.resp_data, 32'd5);
    step();
    check_eq("t3_ready0_c3", 32'(f0.req_ready), 32'd0);
    check_eq("t3_ready1_c3", 32'(f1.req_ready), 32'd1);
    step();
    check_eq("t3_ready0_c4", 32'(f0.req_ready), 32'd1);
    check_eq("t3_ready1_c4", 32'(f1.req_ready), 32'd0);
    check_eq("t3_resp0_data_c4", f0.resp_data, 32'd7);
    step();
    check_eq("t3_ready1_c5", 32'(f1.req_ready), 32'd1);
    check_eq("t3_resp1_data_c5", f1.resp_data, 32'd2);
    f0.req_valid = 1'b0; f1.req_valid = 1'b0;
    step(); step(); step();
    check_eq("t3_busy_drained", 32'(fp_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/sc_alu_arbiter.md
Name: sc_alu_arbiter

Overview:
Shares the single registered sc_alu between two requesters: req 0 is the execute stage, req 1 is the address/auxiliary unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin (or fixed-priority by parameter), with at most one ALU issue per cycle. The block tracks the one-cycle ALU latency and steers each result into a one-entry response register for the owning requester.

Parameters:
WORD_SIZE, `WORD_SIZE (32), operand/result width; must match sc_alu.
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, req 0 wins.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid / req1_valid  in  1  request present.
req0_ready / req1_ready  out  1  request accepted this cycle (grant).
req0_op / req1_op  in  3  ALU opcode (SC_ALU_* encodings).
req0_a / req1_a  in  WORD_SIZE  operand A.
req0_b / req1_b  in  WORD_SIZE  operand B.
resp0_valid / resp1_valid  out  1  result held for requester.
resp0_ready / resp1_ready  in  1  requester consumes result.
resp0_data / resp1_data  out  WORD_SIZE  result.
alu_op_out  out  3  to sc_alu alu_op_in.
alu_a_out  out  WORD_SIZE  to sc_alu alu_a_in.
alu_b_out  out  WORD_SIZE  to sc_alu alu_b_in.
alu_in  in  WORD_SIZE  from sc_alu alu_out.
busy  out  1  any op in flight or any response pending.

Behaviour:
- Reset (async, rst_n=0):
  - inflight_v=0, inflight_id=0, resp*_valid=0, resp*_data=0.
  - last_grant=1, so req 0 wins the first contention.
  - All outputs are 0 during reset. alu_op_out=SC_ALU_ADD (0 encoding), operands 0.
- Eligibility per requester i:
  - eligible_i = reqi_valid & !(inflight_v & inflight_id==i) & (!respi_valid | respi_ready).
- Grant (combinational, one-hot or none):
  - Only one eligible: it wins.
  - Both eligible, RR_EN=1: winner = !last_grant.
  - Both eligible, RR_EN=0: req 0 wins.
  - reqi_ready = grant_i. A request is accepted when valid & ready at an edge.
- ALU drive (combinational):
  - Granted requester's op/a/b is muxed to alu_*_out.
  - No grant: op=SC_ALU_ADD, a=b=0; the result is ignored.
  - sc_alu samples at the same edge E0.
- Tracking:
  - At E0 with a grant: inflight_v<=1, inflight_id<=winner, last_grant<=winner.
  - At E0 with no grant: inflight_v<=0.
- Capture:
  - At E1, if inflight_v: respX_data<=alu_in, respX_valid<=1 for X=inflight_id.
- Latency:
  - Accepted in cycle 0, resp valid from cycle 2.
  - Per-requester max rate is 1 op / 2 cycles; combined rate is 1 op / cycle.
- Response hold:
  - respi_valid/data stay stable until respi_ready. Clear at the edge where valid&ready.
  - Drain and capture of the same slot never coincide; the eligibility rule guarantees this.
- Data width: no width changes; alu_in is taken verbatim.
- Request stability: requesters hold op/a/b stable while valid & !ready. The arbiter does not check this.
- busy = inflight_v | resp0_valid | resp1_valid.
- Reset mid-operation: in-flight op and pending responses are discarded; no response is produced after reset release.
- Simultaneous drain of resp i and new grant to i in the same cycle: legal. The slot is empty at the capture edge.

Decomposition:
- sc_defines.v already holds WORD_SIZE and the SC_ALU_* opcode encodings. Add SC_ALU_OP_W (3) and SC_ALU_NOP (=SC_ALU_ADD) there.
- Sub-module sc_rr_arb2: 2-way round-robin/fixed-priority arbiter.
  - Inputs: eligible[1:0], last_grant, RR_EN.
  - Output: one-hot grant[1:0].
- sc_alu_arbiter instantiates sc_rr_arb2. The testbench instantiates sc_alu_arbiter together with a real sc_alu.

Test Plan:
1. Reset then single request: req0 ADD a=5 b=7 -> req0_ready in cycle 0; resp0_valid=1, resp0_data=12 in cycle 2; busy=1 in cycles 1–2.
2. Contention, RR_EN=1: both valid every cycle, resp_ready=1, req0 SUB 10-3, req1 XOR 0xF0^0x0F.
   - Grants alternate 0,1,0,1 from the first cycle.
   - resp0=7, resp1=0xFF, each two cycles after grant.
3. Contention, RR_EN=0: both valid continuously -> req 0 granted on every cycle it is eligible (every other cycle); req 1 granted only in the gaps.
4. Backpressure: resp0_ready=0 with resp0 full (SLL 1<<4=16) -> req0_ready stays 0 while req1 proceeds. Release ready -> same-cycle drain of 16 and new grant to req0.
5. Async reset mid-flight: assert rst_n=0 one cycle after accepting req1 OR 0xA0|0x05 -> resp1_valid never asserts after release; busy=0, last_grant=1.
6. SRA/SRL passthrough: a=0x80000000, b=4, op SRL -> resp=0x08000000. Result is bit-exact with sc_alu output.
